// File: rtl/game_stage_fsm.sv
// Game-progress controller: walks puzzle stages on activation tiles, gating every change on a redraw handshake.
// Optional redraw watchdog: define GAME_STAGE_REDRAW_TIMEOUT_EN.
module game_stage_fsm #(
  parameter int NUM_STAGES = 4,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 1048575
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      activate,
  input  logic                      sprite_dead,
  input  logic                      done_redraw,
  input  logic [X_W-1:0]            char_x,
  input  logic [Y_W-1:0]            char_y,
  input  logic [NUM_STAGES*X_W-1:0] fwd_x,
  input  logic [NUM_STAGES*Y_W-1:0] fwd_y,
  input  logic [NUM_STAGES*X_W-1:0] back_x,
  input  logic [NUM_STAGES*Y_W-1:0] back_y,
  input  logic [X_W-1:0]            goal_x,
  input  logic [Y_W-1:0]            goal_y,
  output logic [$clog2(NUM_STAGES)-1:0] stage,
  output logic                      redraw_req,
  output logic                      dir,
  output logic                      busy,
  output logic                      finished,
  output logic                      redraw_err
);

  localparam int SW = $clog2(NUM_STAGES);

  typedef enum logic [1:0] {S_REDRAW, S_STABLE, S_FINISHED} state_t;

  state_t        state, state_n;
  logic [SW-1:0] stage_n;
  logic          dir_n;
  logic          act_q;
  logic          act_rise;
  logic          is_last, fwd_hit, back_hit, goal_hit;

  // Bounds are one bit wider than the coordinate and clamped, so a tile near 0 or the edge never wraps.
  function automatic logic near_x(input logic [X_W-1:0] c, input logic [X_W-1:0] p);
    logic [X_W:0] lo, hi, cw, pw, tw;
    cw = {1'b0, c};
    pw = {1'b0, p};
    tw = (X_W+1)'(TOL);
    lo = (pw < tw) ? '0 : pw - tw;
    hi = pw + tw;
    if (hi > {1'b0, {X_W{1'b1}}}) hi = {1'b0, {X_W{1'b1}}};
    return (cw >= lo) && (cw <= hi);
  endfunction

  function automatic logic near_y(input logic [Y_W-1:0] c, input logic [Y_W-1:0] p);
    logic [Y_W:0] lo, hi, cw, pw, tw;
    cw = {1'b0, c};
    pw = {1'b0, p};
    tw = (Y_W+1)'(TOL);
    lo = (pw < tw) ? '0 : pw - tw;
    hi = pw + tw;
    if (hi > {1'b0, {Y_W{1'b1}}}) hi = {1'b0, {Y_W{1'b1}}};
    return (cw >= lo) && (cw <= hi);
  endfunction

  assign act_rise = activate & ~act_q;
  assign is_last  = (int'(stage) == NUM_STAGES - 1);
  assign fwd_hit  = !is_last &&
                    near_x(char_x, fwd_x[int'(stage)*X_W +: X_W]) &&
                    near_y(char_y, fwd_y[int'(stage)*Y_W +: Y_W]);
  assign back_hit = (stage != '0) &&
                    near_x(char_x, back_x[int'(stage)*X_W +: X_W]) &&
                    near_y(char_y, back_y[int'(stage)*Y_W +: Y_W]);
  assign goal_hit = is_last && near_x(char_x, goal_x) && near_y(char_y, goal_y);

`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          err, err_n;
`endif

  always_comb begin
    state_n = state;
    stage_n = stage;
    dir_n   = dir;
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = err;
`endif
    unique case (state)
      S_REDRAW: begin
        if (done_redraw) begin
          state_n = S_STABLE;
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_STABLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
`endif
        end
      end
      S_STABLE: begin
        if (sprite_dead) begin
          stage_n = '0;
          dir_n   = 1'b0;
          state_n = S_REDRAW;
        end else if (goal_hit) begin
          state_n = S_FINISHED;
        end else if (act_rise && fwd_hit) begin
          stage_n = stage + SW'(1);
          dir_n   = 1'b1;
          state_n = S_REDRAW;
        end else if (act_rise && back_hit) begin
          stage_n = stage - SW'(1);
          dir_n   = 1'b0;
          state_n = S_REDRAW;
        end
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
        if (state_n == S_REDRAW) cnt_n = '0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= S_REDRAW;
      stage <= '0;
      dir   <= 1'b0;
      act_q <= 1'b0;
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
      cnt   <= '0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      stage <= stage_n;
      dir   <= dir_n;
      act_q <= activate;
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
      cnt   <= cnt_n;
      err   <= err_n;
`endif
    end
  end

  assign redraw_req = (state == S_REDRAW);
  assign busy       = (state == S_REDRAW);
  assign finished   = (state == S_FINISHED);
`ifdef GAME_STAGE_REDRAW_TIMEOUT_EN
  assign redraw_err = err;
`else
  assign redraw_err = 1'b0;
`endif

endmodule
